uart_receiver: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_receiver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and line levels.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DefSamplesPerBit = 16;
    localparam int unsigned DefDataBits      = 8;
    localparam bit          DefParityOdd     = 1'b0;

    localparam logic StartBit = 1'b0;
    localparam logic StopBit  = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; the reset value is chosen
// to match the input's idle level so that reset does not create a false edge.
module uart_sync2 #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start detection, mid-bit sampling of data, parity and
// stop bits, and a one-cycle valid strobe with held data and error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = DefSamplesPerBit,
    parameter int unsigned DATA_BITS       = DefDataBits,
    parameter bit          PARITY_ODD      = DefParityOdd
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int unsigned CntW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SAMPLES_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 rxd_s;

    uart_sync2 #(
        .ResetValue (1'b1)
    ) u_rxd_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (RxD),
        .q_o    (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            // Strobe lasts one clk regardless of tick timing.
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else if (sample_ENABLE) begin
                unique case (state_q)
                    StIdle: begin
                        if (rxd_s == StartBit) begin
                            state_q <= StStart;
                            cnt_q   <= '0;
                        end
                    end
                    StStart: begin
                        if (cnt_q == CntHalf) begin
                            cnt_q <= '0;
                            // A start bit that is gone by mid-bit was a glitch.
                            if (rxd_s == StartBit) begin
                                state_q <= StData;
                                idx_q   <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (cnt_q == CntLast) begin
                            cnt_q          <= '0;
                            shift_q[idx_q] <= rxd_s;
                            if (idx_q == IdxLast) begin
                                idx_q   <= '0;
                                state_q <= StParity;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StParity: begin
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            perr_q  <= ((^shift_q) ^ rxd_s) != PARITY_ODD;
                            state_q <= StStop;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (cnt_q == CntLast) begin
                            cnt_q     <= '0;
                            state_q   <= StIdle;
                            Rx_DATA   <= shift_q;
                            Rx_PERROR <= perr_q;
                            Rx_FERROR <= (rxd_s != StopBit);
                            Rx_VALID  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
